key_pulse_conditioner: RTL

- Upstream input stage for the light-array cells: converts two raw, asynchronous, bouncy push-button inputs into clean single-cycle move pulses L and R.
- Every light cell (centre and normal) consumes L and R directly; one press yields exactly one pulse, so a held key moves the light one position only.
- Per channel: 2-flop synchronizer, debounce FSM with stable-level counter, press one-shot.

---
 rtl/key_pkg.sv | 21 ++
 rtl/key_pulse_conditioner_if.sv | 19 +
 rtl/key_channel.sv | 117 +++++++++++
 rtl/key_pulse_conditioner.sv | 34 +++
 4 files changed

// File: rtl/key_pkg.sv
// Shared types and constants for the key pulse conditioner channels.
package key_pkg;

  typedef enum logic [1:0] {
    IDLE,
    PRESS_WAIT,
    PRESSED,
    RELEASE_WAIT
  } key_state_t;

  localparam int CNT_W         = 8;
  localparam int RPT_W         = 16;
  localparam int REPEAT_DELAY  = 500;
  localparam int REPEAT_PERIOD = 100;

  // Counter increment that sticks at all-ones instead of wrapping.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] value);
    return (&value) ? value : value + CNT_W'(1);
  endfunction

endpackage

// File: rtl/key_pulse_conditioner_if.sv
// Raw key inputs and conditioned move pulses / debounced levels.
interface key_pulse_conditioner_if;
  logic key_l_raw;
  logic key_r_raw;
  logic L;
  logic R;
  logic held_l;
  logic held_r;

  modport master (
    output key_l_raw, key_r_raw,
    input  L, R, held_l, held_r
  );

  modport slave (
    input  key_l_raw, key_r_raw,
    output L, R, held_l, held_r
  );
endinterface

// File: rtl/key_channel.sv
// One key: 2-flop synchronizer, debounce FSM with saturating counter, press one-shot.
// Optional autorepeat while held is compiled in with KEY_PULSE_AUTOREPEAT_EN.
module key_channel
  import key_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter bit ACTIVE_LOW      = 1'b1
) (
  input  logic clk,
  input  logic reset,
  input  logic key_raw,
  output logic pulse,
  output logic held
);

  localparam logic [CNT_W-1:0] DEB_LIMIT = CNT_W'(DEBOUNCE_CYCLES);

  logic             sync1_reg, sync2_reg;
  key_state_t       state_reg, state_next;
  logic [CNT_W-1:0] cnt_reg, cnt_next;
  logic             pulse_reg, pulse_next;
  logic             press_edge;

  always_ff @(posedge clk) begin
    if (reset) begin
      sync1_reg <= 1'b0;
      sync2_reg <= 1'b0;
      state_reg <= IDLE;
      cnt_reg   <= '0;
      pulse_reg <= 1'b0;
    end else begin
      // Polarity is folded in here so everything downstream is active-high.
      sync1_reg <= key_raw ^ ACTIVE_LOW;
      sync2_reg <= sync1_reg;
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      pulse_reg <= pulse_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    press_edge = 1'b0;
    case (state_reg)
      IDLE: begin
        if (sync2_reg) begin
          state_next = PRESS_WAIT;
          cnt_next   = CNT_W'(1);
        end
      end
      PRESS_WAIT: begin
        if (!sync2_reg) begin
          state_next = IDLE;
          cnt_next   = '0;
        end else if (cnt_reg == DEB_LIMIT) begin
          state_next = PRESSED;
          cnt_next   = '0;
          press_edge = 1'b1;
        end else begin
          cnt_next   = sat_inc(cnt_reg);
        end
      end
      PRESSED: begin
        if (!sync2_reg) begin
          state_next = RELEASE_WAIT;
          cnt_next   = CNT_W'(1);
        end
      end
      RELEASE_WAIT: begin
        if (sync2_reg) begin
          state_next = PRESSED;
          cnt_next   = '0;
        end else if (cnt_reg == DEB_LIMIT) begin
          state_next = IDLE;
          cnt_next   = '0;
        end else begin
          cnt_next   = sat_inc(cnt_reg);
        end
      end
      default: begin
        state_next = IDLE;
        cnt_next   = '0;
      end
    endcase
  end

`ifdef KEY_PULSE_AUTOREPEAT_EN
  logic [RPT_W-1:0] rpt_reg;
  logic             rpt_run;
  logic             rpt_fire;

  always_comb begin
    rpt_run  = (state_reg == PRESSED) && sync2_reg;
    rpt_fire = rpt_run && (rpt_reg == RPT_W'(REPEAT_DELAY - 1));
  end

  // After the first repeat, rewind so the next fire lands one period later.
  always_ff @(posedge clk) begin
    if (reset || !rpt_run) begin
      rpt_reg <= '0;
    end else if (rpt_fire) begin
      rpt_reg <= RPT_W'(REPEAT_DELAY - REPEAT_PERIOD);
    end else begin
      rpt_reg <= rpt_reg + RPT_W'(1);
    end
  end

  always_comb pulse_next = press_edge | rpt_fire;
`else
  always_comb pulse_next = press_edge;
`endif

  assign pulse = pulse_reg;
  assign held  = (state_reg == PRESSED) || (state_reg == RELEASE_WAIT);

endmodule

// File: rtl/key_pulse_conditioner.sv
// Two independent key channels producing clean L/R move pulses.
// Define KEY_PULSE_AUTOREPEAT_EN to enable autorepeat while a key is held.
module key_pulse_conditioner #(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter bit ACTIVE_LOW      = 1'b1
) (
  input logic                      clk,
  input logic                      reset,
  key_pulse_conditioner_if.slave   keys
);

  key_channel #(
    .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
    .ACTIVE_LOW      (ACTIVE_LOW)
  ) u_left (
    .clk     (clk),
    .reset   (reset),
    .key_raw (keys.key_l_raw),
    .pulse   (keys.L),
    .held    (keys.held_l)
  );

  key_channel #(
    .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
    .ACTIVE_LOW      (ACTIVE_LOW)
  ) u_right (
    .clk     (clk),
    .reset   (reset),
    .key_raw (keys.key_r_raw),
    .pulse   (keys.R),
    .held    (keys.held_r)
  );

endmodule
